// File: rtl/stepper_move_controller_if.sv
// Command handshake between the Pi-link front end and the stepper move sequencer.
interface stepper_move_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/stepper_move_controller.sv
// Full-step 4-coil move sequencer: accepts direction/count commands, steps at a fixed rate,
// tracks absolute position and stops on abort or limit switches.
module stepper_move_controller #(
  parameter int STEP_CYCLES   = 250000,
  parameter int SETTLE_CYCLES = 250000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stepper_move_controller_if.slave cmd,
  input  logic                     abort,
  input  logic                     limit_up,
  input  logic                     limit_down,
  output logic [0:3]               coils,
  output logic                     busy,
  output logic                     done,
  output logic                     stopped_early,
  output logic [15:0]              steps_left,
  output logic signed [15:0]       position
);

  localparam int TMAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic signed [15:0] pos_q, pos_d;
  logic [15:0]        steps_q, steps_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               stopped_q, stopped_d;
  logic               lim_up_meta_q, lim_up_s_q;
  logic               lim_dn_meta_q, lim_dn_s_q;

  logic               lim_cmd_dir;
  logic               lim_cur_dir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      pos_q         <= '0;
      steps_q       <= '0;
      timer_q       <= '0;
      dir_q         <= 1'b0;
      done_q        <= 1'b0;
      stopped_q     <= 1'b0;
      lim_up_meta_q <= 1'b0;
      lim_up_s_q    <= 1'b0;
      lim_dn_meta_q <= 1'b0;
      lim_dn_s_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pos_q         <= pos_d;
      steps_q       <= steps_d;
      timer_q       <= timer_d;
      dir_q         <= dir_d;
      done_q        <= done_d;
      stopped_q     <= stopped_d;
      lim_up_meta_q <= limit_up;
      lim_up_s_q    <= lim_up_meta_q;
      lim_dn_meta_q <= limit_down;
      lim_dn_s_q    <= lim_dn_meta_q;
    end
  end

  assign lim_cmd_dir = cmd.cmd_dir ? lim_dn_s_q : lim_up_s_q;
  assign lim_cur_dir = dir_q ? lim_dn_s_q : lim_up_s_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    steps_d   = steps_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    stopped_d = stopped_q;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          // Rejected commands still complete with a done pulse; zero-step is a clean finish.
          if (cmd.cmd_steps == 16'd0 || lim_cmd_dir || abort) begin
            done_d    = 1'b1;
            stopped_d = lim_cmd_dir || abort;
          end else begin
            dir_d     = cmd.cmd_dir;
            steps_d   = cmd.cmd_steps;
            timer_d   = '0;
            stopped_d = 1'b0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (abort || lim_cur_dir) begin
          state_d   = SETTLE;
          timer_d   = '0;
          stopped_d = 1'b1;
        end else if (timer_q == TW'(STEP_CYCLES - 1)) begin
          timer_d = '0;
          idx_d   = dir_q ? idx_q - 2'd1 : idx_q + 2'd1;
          pos_d   = dir_q ? pos_q - 16'sd1 : pos_q + 16'sd1;
          if (steps_q != 16'd0) steps_d = steps_q - 16'd1;
          if (steps_q <= 16'd1) state_d = SETTLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SETTLE: begin
        if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coils = 4'b1111;
    if (state_q != IDLE) begin
      case (idx_q)
        2'd0: coils = 4'b0011;
        2'd1: coils = 4'b1001;
        2'd2: coils = 4'b1100;
        default: coils = 4'b0110;
      endcase
    end
  end

  assign cmd.cmd_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign stopped_early  = stopped_q;
  assign steps_left     = steps_q;
  assign position       = pos_q;

endmodule

// File: tb/tb_stepper_move_controller.sv
// Randomized bench for stepper_move_controller; expected coil/position/step timelines come from
// closed-form arithmetic on the move rules (step k at k*S cycles, done at N*S+SETTLE+1).
module tb_stepper_move_controller;
  localparam int S  = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic limit_up = 1'b0;
  logic limit_down = 1'b0;
  logic [0:3] coils;
  logic busy, done, stopped_early;
  logic [15:0] steps_left;
  logic signed [15:0] position;

  int n_checks = 0;
  int n_pass = 0;
  int m_pos = 0;
  int m_idx = 0;

  always #5 clk = ~clk;

  stepper_move_controller_if cmd_if ();

  stepper_move_controller #(.STEP_CYCLES(S), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .abort(abort),
    .limit_up(limit_up), .limit_down(limit_down), .coils(coils), .busy(busy),
    .done(done), .stopped_early(stopped_early), .steps_left(steps_left), .position(position)
  );

  function automatic logic [0:3] pat(input int i);
    case (((i % 4) + 4) % 4)
      0: return 4'b0011;
      1: return 4'b1001;
      2: return 4'b1100;
      default: return 4'b0110;
    endcase
  endfunction

  // Offers one command; returns at the sampling point of cycle 1 after the accept edge.
  task automatic issue(input logic d, input int n);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_steps = 16'(n);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] o, e;
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir = 1'b0;
    cmd_if.cmd_steps = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      o = {busy, done, cmd_if.cmd_ready, stopped_early, coils, steps_left, position};
      e = {4'b0010, 4'b1111, 16'd0, 16'd0};
      n_checks++;
      if (o !== e) $display("FAIL reset_idle c=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
    end
    $display("reset: idle 10 cycles checked");
  endtask

  task automatic test_moves();
    int dirs[3] = '{0, 1, 0};
    int ns[3]   = '{5, 6, 100};
    int abs[3]  = '{0, 0, 10};
    for (int mi = 0; mi < 9; mi++) begin
      int d, n, a, taken, done_c, sgn, k;
      logic exp_st;
      logic [38:0] o, e;
      if (mi < 3) begin
        d = dirs[mi]; n = ns[mi]; a = abs[mi];
      end else begin
        d = int'($urandom_range(0, 1));
        n = int'($urandom_range(1, 6));
        a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * S + ST)) : 0;
      end
      sgn = (d != 0) ? -1 : 1;
      if (a != 0 && a <= n * S) begin
        taken = (a - 1) / S;
        if (taken > n) taken = n;
        done_c = a + ST + 1;
        exp_st = 1'b1;
      end else begin
        taken = n;
        done_c = n * S + ST + 1;
        exp_st = 1'b0;
      end
      issue(d[0], n);
      for (int c = 1; c <= done_c; c++) begin
        if (c > 1) @(negedge clk);
        abort = (c == a);
        k = (c - 1) / S;
        if (k > taken) k = taken;
        o = {busy, done, cmd_if.cmd_ready, coils, steps_left, position};
        if (c == done_c) e = {3'b011, 4'b1111, 16'(n - k), 16'(m_pos + sgn * k)};
        else             e = {3'b100, pat(m_idx + sgn * k), 16'(n - k), 16'(m_pos + sgn * k)};
        n_checks++;
        if (o !== e) $display("FAIL move%0d c=%0d got=%h exp=%h", mi, c, o, e);
        else n_pass++;
      end
      n_checks++;
      if (stopped_early !== exp_st) $display("FAIL move%0d_stopped got=%b exp=%b", mi, stopped_early, exp_st);
      else n_pass++;
      abort = 1'b0;
      m_idx = (((m_idx + sgn * taken) % 4) + 4) % 4;
      m_pos = m_pos + sgn * taken;
      $display("move %0d dir=%0d steps=%0d abort_cyc=%0d taken=%0d done_cyc=%0d pos=%0d",
               mi, d, n, a, taken, done_c, m_pos);
    end
  endtask

  task automatic test_limit();
    int k;
    logic [38:0] o, e;
    logic [8:0] o2, e2;
    issue(1'b1, 50);
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 9) limit_down = 1'b1;
      k = (c - 1) / S;
      if (k > 2) k = 2;
      o = {busy, done, cmd_if.cmd_ready, coils, steps_left, position};
      if (c == 15) e = {3'b011, 4'b1111, 16'(50 - k), 16'(m_pos - k)};
      else         e = {3'b100, pat(m_idx - k), 16'(50 - k), 16'(m_pos - k)};
      n_checks++;
      if (o !== e) $display("FAIL limit_move c=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
    end
    n_checks++;
    if (stopped_early !== 1'b1) $display("FAIL limit_stopped got=%b exp=1", stopped_early);
    else n_pass++;
    m_pos -= 2;
    m_idx = (m_idx + 2) % 4;
    $display("limit: down 50 stopped after 2 steps pos=%0d", m_pos);

    issue(1'b1, 7);
    o2 = {busy, done, stopped_early, coils, 2'(position == 16'(m_pos))};
    e2 = {3'b011, 4'b1111, 2'd1};
    n_checks++;
    if (o2 !== e2) $display("FAIL limit_reject got=%h exp=%h", o2, e2);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL limit_reject_after got=%b exp=00", {busy, done});
    else n_pass++;
    $display("limit: down command rejected while limit held");

    issue(1'b0, 1);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      k = (c - 1) / S;
      if (k > 1) k = 1;
      o = {busy, done, cmd_if.cmd_ready, coils, steps_left, position};
      if (c == 8) e = {3'b011, 4'b1111, 16'(1 - k), 16'(m_pos + k)};
      else        e = {3'b100, pat(m_idx + k), 16'(1 - k), 16'(m_pos + k)};
      n_checks++;
      if (o !== e) $display("FAIL limit_up_move c=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
    end
    m_pos += 1;
    m_idx = (m_idx + 1) % 4;
    limit_down = 1'b0;
    repeat (3) @(negedge clk);
    $display("limit: up 1 step accepted with down limit held pos=%0d", m_pos);
  endtask

  task automatic test_zero_steps();
    logic [7:0] o, e;
    issue(1'b0, 0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      o = {busy, done, stopped_early, 1'(position == 16'(m_pos)), coils};
      e = {1'b0, 1'(c == 1), 2'b01, 4'b1111};
      n_checks++;
      if (o !== e) $display("FAIL zero_steps c=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
    end
    $display("zero: cmd_steps=0 completes immediately");
    @(negedge clk);
    abort = 1'b1;
    issue(1'b0, 3);
    abort = 1'b0;
    o = {busy, done, stopped_early, 1'(position == 16'(m_pos)), coils};
    e = {4'b0111, 4'b1111};
    n_checks++;
    if (o !== e) $display("FAIL abort_at_accept got=%h exp=%h", o, e);
    else n_pass++;
    @(negedge clk);
    $display("zero: abort at accept completes immediately, stopped early");
  endtask

  task automatic test_hold_valid();
    int k;
    logic [38:0] o, e;
    issue(1'b0, 2);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_steps = 16'd1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 13) cmd_if.cmd_valid = 1'b0;
      if (c <= 12) begin
        k = (c - 1) / S;
        if (k > 2) k = 2;
        if (c == 12) e = {3'b011, 4'b1111, 16'(2 - k), 16'(m_pos + k)};
        else         e = {3'b100, pat(m_idx + k), 16'(2 - k), 16'(m_pos + k)};
      end else begin
        k = (c - 13) / S;
        if (k > 1) k = 1;
        if (c == 20) e = {3'b011, 4'b1111, 16'(1 - k), 16'(m_pos + 2 - k)};
        else         e = {3'b100, pat(m_idx + 2 - k), 16'(1 - k), 16'(m_pos + 2 - k)};
      end
      o = {busy, done, cmd_if.cmd_ready, coils, steps_left, position};
      n_checks++;
      if (o !== e) $display("FAIL hold_valid c=%0d got=%h exp=%h", c, o, e);
      else n_pass++;
    end
    m_pos += 1;
    m_idx = (m_idx + 1) % 4;
    $display("hold: valid held through move, next command taken at done pos=%0d", m_pos);
  endtask

  task automatic test_reset_midmove();
    logic [38:0] o, e;
    issue(1'b0, 5);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    o = {busy, done, cmd_if.cmd_ready, coils, steps_left, position};
    e = {3'b001, 4'b1111, 16'd0, 16'd0};
    n_checks++;
    if (o !== e) $display("FAIL reset_midmove got=%h exp=%h", o, e);
    else n_pass++;
    m_pos = 0;
    m_idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL reset_no_done c=%0d got=%b exp=00", c, {busy, done});
      else n_pass++;
    end
    issue(1'b0, 1);
    n_checks++;
    if ({busy, coils} !== {1'b1, 4'b0011}) $display("FAIL reset_phase got=%h exp=%h", {busy, coils}, {1'b1, 4'b0011});
    else n_pass++;
    repeat (7) @(negedge clk);
    n_checks++;
    if ({done, position} !== {1'b1, 16'sd1}) $display("FAIL reset_after_move got=%h exp=%h", {done, position}, {1'b1, 16'sd1});
    else n_pass++;
    $display("reset: mid-move reset discarded move, phase restarted at 0");
  endtask

  initial begin
    test_reset();
    test_moves();
    test_limit();
    test_zero_steps();
    test_hold_valid();
    test_reset_midmove();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
